div_share_ctrl: RTL and testbench
=================================

Name: div_share_ctrl

Overview:
Sequences and shares one multi-cycle 32-bit unsigned divider (start/ready handshake, quotient and remainder outputs) between NREQ requesters in the shader core.
- Arbitrates requests round-robin and converts signed DIV/REM to magnitude division, restoring signs afterwards.
- Short-circuits divide-by-zero and signed overflow without engaging the divider.
- Returns one tagged result at a time.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, width of rsp_id; must satisfy 2^IDW >= NREQ

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester request
req_ready  out  NREQ  one-hot accept; combinational, only in IDLE
req_op  in  2*NREQ  per requester: 0 DIV, 1 DIVU, 2 REM, 3 REMU
req_a  in  32*NREQ  dividend per requester
req_b  in  32*NREQ  divisor per requester
rsp_valid  out  1  result valid; held until rsp_ready
rsp_ready  in  1  consumer accepts result
rsp_id  out  IDW  index of the requester that owns the result
rsp_data  out  32  quotient or remainder, per op
div_start  out  1  divider start pulse
div_dividend  out  32  magnitude dividend; stable from START until capture
div_divisor  out  32  magnitude divisor; stable from START until capture
div_ready  in  1  divider idle/done flag; high when idle, low while calculating
div_quot  in  32  divider quotient
div_rem  in  32  divider remainder

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, div_start=0, div_dividend=0, div_divisor=0, FSM=IDLE, rr_ptr=0. Reset mid-operation abandons the job. The divider is reset by the same rst_n.
- States: IDLE, START, WAIT_LO, WAIT_HI, FIX, RESP.
- IDLE:
  - Grant is the first valid index at or after rr_ptr, wrapping modulo NREQ. req_ready[grant]=1 while any req_valid is high.
  - On accept, latch id, op, a and b. rr_ptr <= grant+1, wrapping to 0.
  - Signed ops (DIV, REM): compute magnitudes |a| and |b|. Record neg_q = a[31]^b[31] and neg_r = a[31].
- Bypass cases, evaluated at accept; next state is RESP with the result loaded, so rsp_valid appears the cycle after accept:
  - b==0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give a.
  - Signed op with a=0x80000000 and b=0xFFFFFFFF: DIV gives 0x80000000; REM gives 0.
- Otherwise the next state is START.
- START: div_start=1 for exactly one cycle with the operands driven. Next state is WAIT_LO.
- WAIT_LO: wait for div_ready==0, then go to WAIT_HI. Timeout: if div_ready remains high for 2 cycles, reissue START.
- WAIT_HI: wait for div_ready==1, then capture div_quot and div_rem and go to FIX.
- FIX:
  - Select quotient (ops 0, 1) or remainder (ops 2, 3).
  - Negate the quotient if neg_q and the op is signed; negate the remainder if neg_r and the op is signed.
  - Register the result into rsp_data and go to RESP.
- RESP: rsp_valid=1, with rsp_id and rsp_data stable. On rsp_ready, return to IDLE. A new request can be accepted in the cycle after the handshake, never in the same cycle.
- While not in IDLE, req_ready is all 0. Requesters must hold their operands until accepted.
- Arithmetic is 32-bit two's complement. Negation of 0x80000000 wraps to itself.

Optional Feature:
DIV_SHARE_CACHE_EN
- Enabled: a one-entry cache holds the last divider-computed pair (a, b, signedness, quotient, remainder; bypass results are not cached). An accepted request whose a, b and signed class (signed/unsigned) match a valid entry goes straight to RESP, so rsp_valid appears the cycle after accept. REM after DIV on the same operands therefore costs no divider run. The cache is invalidated by reset.
- Disabled: every non-bypass request runs the divider.

Test Plan:
- Requester 1 sends DIVU a=100, b=7 -> div_start pulse once; rsp_valid with rsp_id=1, rsp_data=14; then REMU on the same operands -> rsp_data=2.
- DIV a=-7 (0xFFFFFFF9), b=2 -> rsp_data=0xFFFFFFFD (-3); REM of the same operands -> 0xFFFFFFFF (-1).
- REMU a=0x1234, b=0 -> rsp_data=0x1234 the cycle after accept, no div_start; DIV a=0x80000000, b=-1 -> 0x80000000.
- All four requesters valid continuously, rr_ptr=0 -> grants in order 0,1,2,3,0; no requester starved.
- Hold rsp_ready=0 for 10 cycles -> rsp_valid, rsp_id and rsp_data stable; req_ready=0 throughout.
- Assert rst_n low during WAIT_HI -> all outputs return to reset values; the next request completes correctly. With DIV_SHARE_CACHE_EN, a repeated DIVU 100/7 gives rsp_data=14 with no div_start.

Source files
------------

// File: rtl/div_share_ctrl.sv
// div_share_ctrl: shares one multi-cycle 32-bit unsigned divider between
// NREQ requesters. Requests are granted round-robin. Signed DIV/REM are turned
// into magnitude division, and the signs are restored afterwards.
// Divide-by-zero and signed overflow are answered without using the divider.
// Optional feature macro: DIV_SHARE_CACHE_EN. When it is defined, a one-entry
// cache holds the last divider result, keyed by a, b and signedness.
//
// Handshakes:
//  - Request: requester i transfers on a rising edge where req_valid[i] and
//    req_ready[i] are both high. req_ready is one-hot and only high in IDLE.
//  - Response: rsp_valid stays high, with rsp_id and rsp_data held, until a
//    rising edge where rsp_ready is high.
//  - Divider: div_start is high for one cycle. The divider drops div_ready
//    while busy and raises it when the quotient and remainder are valid.
module div_share_ctrl #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [2*NREQ-1:0]    req_op,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_data,
  output logic                 div_start,
  output logic [31:0]          div_dividend,
  output logic [31:0]          div_divisor,
  input  logic                 div_ready,
  input  logic [31:0]          div_quot,
  input  logic [31:0]          div_rem,
  output logic [2:0]           dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_WAIT_LO = 3'd2,
    S_WAIT_HI = 3'd3,
    S_FIX     = 3'd4,
    S_RESP    = 3'd5
  } state_t;

  state_t          r_state;
  logic [IDW-1:0]  r_rr_ptr;
  logic [IDW-1:0]  r_rsp_id;
  logic [31:0]     r_rsp_data;
  logic            r_rsp_valid;
  logic            r_div_start;
  logic [31:0]     r_div_dividend;
  logic [31:0]     r_div_divisor;
  logic [1:0]      r_op;
  logic            r_neg_q;
  logic            r_neg_r;
  logic [31:0]     r_quot;
  logic [31:0]     r_rem;
  logic            r_wait_cnt;

  logic            w_any;
  logic [IDW-1:0]  w_grant;
  logic [1:0]      w_sel_op;
  logic [31:0]     w_sel_a;
  logic [31:0]     w_sel_b;
  logic            w_signed;
  logic [31:0]     w_mag_a;
  logic [31:0]     w_mag_b;
  logic            w_neg_q;
  logic            w_neg_r;
  logic            w_div0;
  logic            w_ovf;
  logic [31:0]     w_byp_data;
  logic            w_hit;
  logic [31:0]     w_hit_data;

  // Select the quotient or the remainder. Negate it only for signed ops.
  // Ops 0 and 2 are the signed ops, so bit 0 clear means signed.
  function automatic logic [31:0] fix_result(input logic [1:0] op,
                                             input logic nq, input logic nr,
                                             input logic [31:0] q,
                                             input logic [31:0] r);
    logic [31:0] res;
    if (op[1]) res = (nr && !op[0]) ? (32'd0 - r) : r;
    else       res = (nq && !op[0]) ? (32'd0 - q) : q;
    return res;
  endfunction

  // Round-robin search: take the first valid index at or after r_rr_ptr.
  always_comb begin
    logic [IDW:0] s;
    w_any   = 1'b0;
    w_grant = r_rr_ptr;
    s       = '0;
    for (int i = 0; i < NREQ; i++) begin
      s = {1'b0, r_rr_ptr} + (IDW+1)'(i);
      if (s >= (IDW+1)'(NREQ)) s = s - (IDW+1)'(NREQ);
      if (!w_any && req_valid[s[IDW-1:0]]) begin
        w_any   = 1'b1;
        w_grant = s[IDW-1:0];
      end
    end
  end

  // One-hot accept. It is only offered in IDLE, so accepts never overlap a job.
  always_comb begin
    req_ready = '0;
    if (r_state == S_IDLE && w_any) req_ready[w_grant] = 1'b1;
  end

  assign w_sel_op = req_op[{w_grant, 1'b0} +: 2];
  assign w_sel_a  = req_a[{w_grant, 5'd0} +: 32];
  assign w_sel_b  = req_b[{w_grant, 5'd0} +: 32];
  assign w_signed = ~w_sel_op[0];
  assign w_mag_a  = (w_signed && w_sel_a[31]) ? (32'd0 - w_sel_a) : w_sel_a;
  assign w_mag_b  = (w_signed && w_sel_b[31]) ? (32'd0 - w_sel_b) : w_sel_b;
  assign w_neg_q  = w_sel_a[31] ^ w_sel_b[31];
  assign w_neg_r  = w_sel_a[31];
  assign w_div0   = (w_sel_b == 32'd0);
  assign w_ovf    = w_signed && (w_sel_a == 32'h8000_0000) &&
                    (w_sel_b == 32'hFFFF_FFFF);
  assign w_byp_data = w_div0 ? (w_sel_op[1] ? w_sel_a : 32'hFFFF_FFFF)
                             : (w_sel_op[1] ? 32'd0 : 32'h8000_0000);

`ifdef DIV_SHARE_CACHE_EN
  logic            r_c_valid;
  logic [31:0]     r_c_a;
  logic [31:0]     r_c_b;
  logic            r_c_signed;
  logic [31:0]     r_c_quot;
  logic [31:0]     r_c_rem;
  logic [31:0]     r_a;
  logic [31:0]     r_b;

  assign w_hit = r_c_valid && (r_c_a == w_sel_a) && (r_c_b == w_sel_b) &&
                 (r_c_signed == w_signed);
  assign w_hit_data = fix_result(w_sel_op, w_neg_q, w_neg_r, r_c_quot, r_c_rem);

  // Cache entry: it is filled only from real divider runs and cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c_valid  <= 1'b0;
      r_c_a      <= '0;
      r_c_b      <= '0;
      r_c_signed <= 1'b0;
      r_c_quot   <= '0;
      r_c_rem    <= '0;
      r_a        <= '0;
      r_b        <= '0;
    end else begin
      if (r_state == S_IDLE && w_any) begin
        r_a <= w_sel_a;
        r_b <= w_sel_b;
      end
      if (r_state == S_WAIT_HI && div_ready) begin
        r_c_valid  <= 1'b1;
        r_c_a      <= r_a;
        r_c_b      <= r_b;
        r_c_signed <= ~r_op[0];
        r_c_quot   <= div_quot;
        r_c_rem    <= div_rem;
      end
    end
  end
`else
  assign w_hit      = 1'b0;
  assign w_hit_data = '0;
`endif

  // Main sequencer. All outputs are registered and change only on state transitions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_rr_ptr       <= '0;
      r_rsp_id       <= '0;
      r_rsp_data     <= '0;
      r_rsp_valid    <= 1'b0;
      r_div_start    <= 1'b0;
      r_div_dividend <= '0;
      r_div_divisor  <= '0;
      r_op           <= '0;
      r_neg_q        <= 1'b0;
      r_neg_r        <= 1'b0;
      r_quot         <= '0;
      r_rem          <= '0;
      r_wait_cnt     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_rsp_id <= w_grant;
            r_op     <= w_sel_op;
            r_neg_q  <= w_neg_q;
            r_neg_r  <= w_neg_r;
            r_rr_ptr <= (w_grant == IDW'(NREQ-1)) ? '0 : IDW'(w_grant + 1'b1);
            if (w_div0 || w_ovf) begin
              r_rsp_data  <= w_byp_data;
              r_rsp_valid <= 1'b1;
              r_state     <= S_RESP;
            end else if (w_hit) begin
              r_rsp_data  <= w_hit_data;
              r_rsp_valid <= 1'b1;
              r_state     <= S_RESP;
            end else begin
              r_div_dividend <= w_mag_a;
              r_div_divisor  <= w_mag_b;
              r_div_start    <= 1'b1;
              r_state        <= S_START;
            end
          end
        end
        S_START: begin
          r_div_start <= 1'b0;
          r_wait_cnt  <= 1'b0;
          r_state     <= S_WAIT_LO;
        end
        S_WAIT_LO: begin
          // If the divider stays idle for two cycles, it missed the start pulse.
          if (!div_ready) begin
            r_state <= S_WAIT_HI;
          end else if (r_wait_cnt) begin
            r_div_start <= 1'b1;
            r_state     <= S_START;
          end else begin
            r_wait_cnt <= 1'b1;
          end
        end
        S_WAIT_HI: begin
          if (div_ready) begin
            r_quot  <= div_quot;
            r_rem   <= div_rem;
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_rsp_data  <= fix_result(r_op, r_neg_q, r_neg_r, r_quot, r_rem);
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid    = r_rsp_valid;
  assign rsp_id       = r_rsp_id;
  assign rsp_data     = r_rsp_data;
  assign div_start    = r_div_start;
  assign div_dividend = r_div_dividend;
  assign div_divisor  = r_div_divisor;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_div_share_ctrl.sv
// Directed bench for div_share_ctrl, with a behavioural multi-cycle divider.
module tb_div_share_ctrl;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
`ifdef DIV_SHARE_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_ready;
  logic [2*NREQ-1:0]   req_op = '0;
  logic [32*NREQ-1:0]  req_a = '0;
  logic [32*NREQ-1:0]  req_b = '0;
  logic                rsp_valid;
  logic                rsp_ready = 1'b0;
  logic [IDW-1:0]      rsp_id;
  logic [31:0]         rsp_data;
  logic                div_start;
  logic [31:0]         div_dividend;
  logic [31:0]         div_divisor;
  logic                div_ready;
  logic [31:0]         div_quot;
  logic [31:0]         div_rem;
  logic [2:0]          dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [IDW+31:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  div_share_ctrl #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data),
    .div_start(div_start), .div_dividend(div_dividend),
    .div_divisor(div_divisor), .div_ready(div_ready),
    .div_quot(div_quot), .div_rem(div_rem),
    .dbg_state(dbg_state)
  );

  // Divider model: 5-cycle busy period. It can be told to ignore the next start pulses.
  logic [31:0] dm_dd = '0;
  logic [31:0] dm_dv = '0;
  int dm_cnt = 0;
  int dm_ignore = 0;
  int dm_ignored = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_ready <= 1'b1;
      dm_cnt    <= 0;
      div_quot  <= '0;
      div_rem   <= '0;
    end else if (dm_cnt != 0) begin
      dm_cnt <= dm_cnt - 1;
      if (dm_cnt == 1) begin
        div_ready <= 1'b1;
        div_quot  <= (dm_dv == 0) ? 32'hFFFF_FFFF : dm_dd / dm_dv;
        div_rem   <= (dm_dv == 0) ? dm_dd : dm_dd % dm_dv;
      end
    end else if (div_start && div_ready) begin
      if (dm_ignored < dm_ignore) begin
        dm_ignored <= dm_ignored + 1;
      end else begin
        dm_dd     <= div_dividend;
        dm_dv     <= div_divisor;
        div_ready <= 1'b0;
        dm_cnt    <= 5;
      end
    end
  end

  int start_cnt = 0;
  always @(posedge clk) if (rst_n && div_start) start_cnt <= start_cnt + 1;

  // Round-robin monitors
  bit rr_phase = 1'b0;
  int grant_q[$];
  logic [IDW+31:0] obs_q[$];
  always @(negedge clk) begin
    if (rr_phase) begin
      for (int i = 0; i < NREQ; i++)
        if (req_valid[i] && req_ready[i]) grant_q.push_back(i);
      if (rsp_valid && rsp_ready) obs_q.push_back({rsp_id, rsp_data});
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check_eq({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
    check_eq({tag, "_rsp_data"}, rsp_data, 32'd0);
    check_eq({tag, "_div_start"}, 32'(div_start), 32'd0);
    check_eq({tag, "_dividend"}, div_dividend, 32'd0);
    check_eq({tag, "_divisor"}, div_divisor, 32'd0);
    check_eq({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  // driver: present one request and return just after it is accepted
  task automatic send(input int id, input logic [1:0] op,
                      input logic [31:0] a, input logic [31:0] b);
    int n;
    @(negedge clk);
    req_op[id*2 +: 2]  = op;
    req_a[id*32 +: 32] = a;
    req_b[id*32 +: 32] = b;
    req_valid[id]      = 1'b1;
    n = 0;
    #1;
    while (!req_ready[id] && n < 100) begin
      @(negedge clk); #1; n++;
    end
    check_eq("accept", 32'(req_ready[id]), 32'd1);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  // consume one response and compare it against the head of exp_q
  task automatic get_rsp(input string tag);
    int n;
    logic [IDW+31:0] e;
    n = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge clk); n++;
    end
    check_eq({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    check_eq({tag, "_id"}, 32'(rsp_id), 32'(e[IDW+31:32]));
    check_eq({tag, "_data"}, rsp_data, e[31:0]);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic run(input string tag, input int id, input logic [1:0] op,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_data, input int exp_starts,
                     input bit exp_fast);
    int s0;
    s0 = start_cnt;
    exp_q.push_back({IDW'(id), exp_data});
    send(id, op, a, b);
    @(negedge clk);
    check_eq({tag, "_fast"}, 32'(rsp_valid), 32'(exp_fast));
    get_rsp(tag);
    check_eq({tag, "_starts"}, 32'(start_cnt - s0), 32'(exp_starts));
  endtask

  initial begin
    int n;
    logic [31:0] rr_exp_data[5];
    int rr_exp_id[5];
    rr_exp_id   = '{0, 1, 2, 3, 0};
    rr_exp_data = '{32'd13, 32'd16, 32'd20, 32'd23, 32'd13};

    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // all four requesters valid continuously, starting from rr_ptr = 0
    rr_phase  = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) begin
      req_op[i*2 +: 2]  = 2'd1;
      req_a[i*32 +: 32] = 32'(40 + 10*i);
      req_b[i*32 +: 32] = 32'd3;
    end
    req_valid = '1;
    n = 0;
    while (grant_q.size() < 5 && n < 500) begin
      @(posedge clk); #1; n++;
    end
    req_valid = '0;
    n = 0;
    while (obs_q.size() < 5 && n < 500) begin
      @(negedge clk); n++;
    end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    rr_phase  = 1'b0;
    check_eq("rr_grant_cnt", 32'(grant_q.size()), 32'd5);
    check_eq("rr_rsp_cnt", 32'(obs_q.size()), 32'd5);
    for (int k = 0; k < 5; k++) begin
      check_eq("rr_grant", (k < grant_q.size()) ? 32'(grant_q[k]) : 32'hDEAD,
               32'(rr_exp_id[k]));
      check_eq("rr_rsp_id", (k < obs_q.size()) ? 32'(obs_q[k][IDW+31:32]) : 32'hDEAD,
               32'(rr_exp_id[k]));
      check_eq("rr_rsp_data", (k < obs_q.size()) ? obs_q[k][31:0] : 32'hDEAD,
               rr_exp_data[k]);
    end

    // basic unsigned and signed divides
    run("divu_100_7", 1, 2'd1, 32'd100, 32'd7, 32'd14, 1, 1'b0);
    run("remu_100_7", 1, 2'd3, 32'd100, 32'd7, 32'd2, CACHE ? 0 : 1, CACHE);
    run("div_m7_2",   2, 2'd0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1, 1'b0);
    run("rem_m7_2",   2, 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, CACHE ? 0 : 1, CACHE);
    run("div_7_m2",   3, 2'd0, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1, 1'b0);
    run("rem_7_m2",   3, 2'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, CACHE ? 0 : 1, CACHE);

    // bypass cases: the result appears the cycle after accept, with no divider run
    run("remu_by0",   0, 2'd3, 32'h0000_1234, 32'd0, 32'h0000_1234, 0, 1'b1);
    run("divu_by0",   1, 2'd1, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 0, 1'b1);
    run("div_by0",    2, 2'd0, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, 1'b1);
    run("rem_by0",    3, 2'd2, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 0, 1'b1);
    run("div_ovf",    0, 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1'b1);
    run("rem_ovf",    1, 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, 1'b1);
    // the same operands unsigned are an ordinary divide
    run("divu_big",   2, 2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1'b0);
    run("remu_big",   2, 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, CACHE ? 0 : 1, CACHE);
    run("div_min_2",  3, 2'd0, 32'h8000_0000, 32'd2, 32'hC000_0000, 1, 1'b0);
    run("rem_min_2",  3, 2'd2, 32'h8000_0000, 32'd2, 32'd0, CACHE ? 0 : 1, CACHE);

    // the divider ignores the first start, so the controller must reissue it
    dm_ignore = 1;
    run("timeout",    0, 2'd1, 32'd50, 32'd6, 32'd8, 2, 1'b0);

    // hold the response back while another requester waits
    exp_q.push_back({2'd3, 32'd100});
    send(3, 2'd1, 32'd1000, 32'd10);
    @(negedge clk);
    req_op[1:0]  = 2'd1;
    req_a[31:0]  = 32'd9;
    req_b[31:0]  = 32'd4;
    req_valid[0] = 1'b1;
    n = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge clk); n++;
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_eq("hold_valid", 32'(rsp_valid), 32'd1);
      check_eq("hold_id", 32'(rsp_id), 32'd3);
      check_eq("hold_data", rsp_data, 32'd100);
      check_eq("hold_req_ready", 32'(req_ready), 32'd0);
    end
    get_rsp("hold");
    exp_q.push_back({2'd0, 32'd2});
    send(0, 2'd1, 32'd9, 32'd4);
    get_rsp("held_req");

    // reset in the middle of WAIT_HI
    send(2, 2'd1, 32'd77, 32'd5);
    n = 0;
    while (dbg_state != 3'd3 && n < 100) begin
      @(negedge clk); n++;
    end
    check_eq("reach_wait_hi", 32'(dbg_state), 32'd3);
    rst_n = 1'b0;
    #1;
    check_reset("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    req_op[1:0]   = 2'd1;
    req_a[31:0]   = 32'd77;
    req_b[31:0]   = 32'd5;
    req_valid     = 4'b1001;
    #1;
    check_eq("rr_after_reset", 32'(req_ready), 32'h1);
    req_valid     = '0;
    run("after_reset", 0, 2'd1, 32'd77, 32'd5, 32'd15, 1, 1'b0);
    run("divu_again",  1, 2'd1, 32'd100, 32'd7, 32'd14, 1, 1'b0);
    run("divu_repeat", 1, 2'd1, 32'd100, 32'd7, 32'd14, CACHE ? 0 : 1, CACHE);
    run("div_class",   2, 2'd0, 32'd100, 32'd7, 32'd14, 1, 1'b0);
    check_eq("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
